sim_mem: RTL and testbench



---
 rtl/sim_mem_pkg.sv | 24 ++
 rtl/sim_mem_if.sv | 26 ++
 rtl/sim_mem_rsp_pipe.sv | 36 +++
 rtl/sim_mem.sv | 95 +++++++++
 tb/tb_sim_mem.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_mem_pkg.sv
// Shared sizing helpers and the response record for the simulation memory.
package sim_mem_pkg;

  localparam int unsigned DefaultDW = 32;

  function automatic int unsigned bytes_per_word(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned byte_off_w(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int unsigned word_idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [DefaultDW-1:0] data;
  } sim_mem_rsp_t;

endpackage

// File: rtl/sim_mem_if.sv
// Multi-port req/gnt/rvalid bus; every signal is a flat vector of per-port slices.
interface sim_mem_if #(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32
);
  logic [NumPorts-1:0]        req_i;
  logic [NumPorts-1:0]        gnt_o;
  logic [NumPorts-1:0]        we_i;
  logic [NumPorts*DW/8-1:0]   be_i;
  logic [NumPorts*AW-1:0]     addr_i;
  logic [NumPorts*DW-1:0]     wdata_i;
  logic [NumPorts-1:0]        rvalid_o;
  logic [NumPorts*DW-1:0]     rdata_o;
  logic [NumPorts-1:0]        err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/sim_mem_rsp_pipe.sv
// Fixed-latency response delay line; a synchronous clear drops everything in flight.
module sim_mem_rsp_pipe
  import sim_mem_pkg::*;
#(
  parameter int unsigned Latency = 1,
  parameter type         rsp_t   = sim_mem_rsp_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  rsp_t rsp_i,
  output rsp_t rsp_o
);

  rsp_t stage_q [Latency];
  rsp_t stage_d [Latency];

  always_comb begin
    stage_d[0] = rsp_i;
    for (int i = 1; i < Latency; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Latency; i++) begin
      if (rst_i) begin
        stage_q[i] <= '0;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign rsp_o = stage_q[Latency-1];

endmodule

// File: rtl/sim_mem.sv
// N-port simulation memory: word storage, byte-enable writes, range/read-only
// errors, and a per-port fixed-latency response pipeline.
module sim_mem
  import sim_mem_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned Depth    = 1024,
  parameter int unsigned NumPorts = 2,
  parameter int unsigned Latency  = 1,
  parameter bit          ReadOnly = 1'b0,
  parameter string       File     = ""
) (
  input logic      clk_i,
  input logic      rst_i,
  sim_mem_if.slave bus
);

  localparam int unsigned NB    = bytes_per_word(DW);
  localparam int unsigned OffW  = byte_off_w(DW);
  localparam int unsigned IdxW  = word_idx_w(Depth);
  localparam int unsigned UsedW = OffW + IdxW;

  typedef struct packed {
    logic          valid;
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0]       mem_q [Depth];
  logic [NumPorts-1:0] gnt;
  logic [NumPorts-1:0] in_rng;
  logic [NumPorts-1:0] wr_ok;
  logic [IdxW-1:0]     idx   [NumPorts];
  rsp_t                rsp_d [NumPorts];
  rsp_t                rsp_q [NumPorts];

  initial begin
    if ((DW % 8) != 0) $fatal(1, "sim_mem: DW must be a multiple of 8");
    if ((NB & (NB - 1)) != 0) $fatal(1, "sim_mem: DW/8 must be a power of two");
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) $fatal(1, "sim_mem: Depth must be a power of two >= 2");
    if (Latency < 1 || Latency > 8) $fatal(1, "sim_mem: Latency must be 1..8");
    if (NumPorts < 1 || NumPorts > 4) $fatal(1, "sim_mem: NumPorts must be 1..4");
    if (UsedW > AW) $fatal(1, "sim_mem: memory does not fit in AW address bits");
  end

  // Reads sample mem_q before the edge, so same-cycle writes are never visible.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      gnt[p]    = bus.req_i[p] & ~rst_i;
      idx[p]    = bus.addr_i[p*AW + OffW +: IdxW];
      in_rng[p] = (bus.addr_i[p*AW +: AW] >> UsedW) == '0;
      wr_ok[p]  = gnt[p] & bus.we_i[p] & in_rng[p] & ~ReadOnly;

      rsp_d[p]       = '0;
      rsp_d[p].valid = gnt[p];
      rsp_d[p].err   = gnt[p] & (~in_rng[p] | (bus.we_i[p] & ReadOnly));
      if (gnt[p] & ~bus.we_i[p] & in_rng[p]) begin
        rsp_d[p].data = mem_q[idx[p]];
      end
    end
  end

  // Ascending port order: the highest-numbered port wins each contested byte.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      if (wr_ok[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.be_i[p*NB + b]) begin
            mem_q[idx[p]][b*8 +: 8] <= bus.wdata_i[p*DW + b*8 +: 8];
          end
        end
      end
    end
  end

  assign bus.gnt_o = gnt;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    sim_mem_rsp_pipe #(
      .Latency (Latency),
      .rsp_t   (rsp_t)
    ) u_rsp_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .rsp_i (rsp_d[p]),
      .rsp_o (rsp_q[p])
    );

    assign bus.rvalid_o[p]          = rsp_q[p].valid;
    assign bus.err_o[p]             = rsp_q[p].err;
    assign bus.rdata_o[p*DW +: DW]  = rsp_q[p].data;
  end

endmodule

// File: tb/tb_sim_mem.sv
// Directed bench for sim_mem: four instances cover Latency 1/3/4 and read-only mode.
module tb_sim_mem;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_c = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sim_mem_if #(.NumPorts(2), .AW(32), .DW(32)) if_a ();
  sim_mem_if #(.NumPorts(1), .AW(32), .DW(32)) if_b ();
  sim_mem_if #(.NumPorts(1), .AW(32), .DW(32)) if_c ();
  sim_mem_if #(.NumPorts(1), .AW(32), .DW(32)) if_d ();

  sim_mem #(.AW(32), .DW(32), .Depth(1024), .NumPorts(2), .Latency(1), .ReadOnly(1'b0), .File(""))
    dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
  sim_mem #(.AW(32), .DW(32), .Depth(1024), .NumPorts(1), .Latency(3), .ReadOnly(1'b0), .File(""))
    dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b));
  sim_mem #(.AW(32), .DW(32), .Depth(1024), .NumPorts(1), .Latency(4), .ReadOnly(1'b0), .File(""))
    dut_c (.clk_i(clk), .rst_i(rst_c), .bus(if_c));
  sim_mem #(.AW(32), .DW(32), .Depth(1024), .NumPorts(1), .Latency(1), .ReadOnly(1'b1), .File(""))
    dut_d (.clk_i(clk), .rst_i(rst), .bus(if_d));

  // Byte k of the image holds k mod 256.
  function automatic logic [31:0] pre_word(input int w);
    return {8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1), 8'(4*w)};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_a(input int p, input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if_a.req_i[p]             = req;
    if_a.we_i[p]              = we;
    if_a.be_i[p*4 +: 4]       = be;
    if_a.addr_i[p*32 +: 32]   = addr;
    if_a.wdata_i[p*32 +: 32]  = wdata;
  endtask

  task automatic idle_all();
    drive_a(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_a(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    if_b.req_i = 1'b0; if_b.we_i = 1'b0; if_b.be_i = 4'h0; if_b.addr_i = '0; if_b.wdata_i = '0;
    if_c.req_i = 1'b0; if_c.we_i = 1'b0; if_c.be_i = 4'h0; if_c.addr_i = '0; if_c.wdata_i = '0;
    if_d.req_i = 1'b0; if_d.we_i = 1'b0; if_d.be_i = 4'h0; if_d.addr_i = '0; if_d.wdata_i = '0;
  endtask

  task automatic test_reset();
    step();
    drive_a(0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    #1;
    total++;
    if (if_a.gnt_o !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", if_a.gnt_o); end
    step();
    total++;
    if (if_a.rvalid_o !== 2'b00) begin bad++; $display("FAIL reset_rvalid: got %b want 00", if_a.rvalid_o); end
    total++;
    if (if_a.rdata_o !== 64'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", if_a.rdata_o); end
    total++;
    if (if_a.err_o !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", if_a.err_o); end
    rst = 1'b0;
    rst_c = 1'b0;
    idle_all();
    step();
    total++;
    if (if_a.rvalid_o !== 2'b00) begin bad++; $display("FAIL reset_no_rsp: got %b want 00", if_a.rvalid_o); end
    total++;
    if (if_c.rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_c_rvalid: got %b want 0", if_c.rvalid_o); end
  endtask

  task automatic test_preload();
    drive_a(0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    drive_a(1, 1'b1, 1'b0, 4'hF, 32'hFFC, 32'h0);
    #1;
    total++;
    if (if_a.gnt_o !== 2'b11) begin bad++; $display("FAIL preload_gnt: got %b want 11", if_a.gnt_o); end
    step();
    total++;
    if (if_a.rvalid_o !== 2'b11) begin bad++; $display("FAIL preload_rvalid: got %b want 11", if_a.rvalid_o); end
    total++;
    if (if_a.rdata_o[31:0] !== 32'h07060504) begin bad++; $display("FAIL preload_rd4: got %h want 07060504", if_a.rdata_o[31:0]); end
    total++;
    if (if_a.rdata_o[63:32] !== 32'hFFFEFDFC) begin bad++; $display("FAIL preload_last_word: got %h want fffefdfc", if_a.rdata_o[63:32]); end
    total++;
    if (if_a.err_o !== 2'b00) begin bad++; $display("FAIL preload_err: got %b want 00", if_a.err_o); end
    drive_a(0, 1'b1, 1'b0, 4'hF, 32'h6, 32'h0);
    drive_a(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    idle_all();
    total++;
    if (if_a.rdata_o[31:0] !== 32'h07060504) begin bad++; $display("FAIL preload_low_bits: got %h want 07060504", if_a.rdata_o[31:0]); end
    step();
    total++;
    if (if_a.rvalid_o !== 2'b00 || if_a.rdata_o !== 64'h0) begin
      bad++; $display("FAIL preload_idle: got rvalid %b rdata %h want 00 / 0", if_a.rvalid_o, if_a.rdata_o);
    end
  endtask

  task automatic test_byte_enable();
    drive_a(1, 1'b1, 1'b1, 4'b0101, 32'h10, 32'hAABBCCDD);
    step();
    total++;
    if (if_a.rvalid_o !== 2'b10 || if_a.err_o !== 2'b00 || if_a.rdata_o[63:32] !== 32'h0) begin
      bad++; $display("FAIL be_wr_rsp: got rvalid %b err %b rdata %h want 10/00/0", if_a.rvalid_o, if_a.err_o, if_a.rdata_o[63:32]);
    end
    drive_a(1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    drive_a(0, 1'b1, 1'b1, 4'h0, 32'h14, 32'hFFFFFFFF);
    step();
    total++;
    if (if_a.rdata_o[63:32] !== 32'h13BB11DD) begin bad++; $display("FAIL be_merge: got %h want 13bb11dd", if_a.rdata_o[63:32]); end
    total++;
    if (if_a.rvalid_o[0] !== 1'b1 || if_a.err_o[0] !== 1'b0 || if_a.rdata_o[31:0] !== 32'h0) begin
      bad++; $display("FAIL be_zero_rsp: got rvalid %b err %b rdata %h want 1/0/0", if_a.rvalid_o[0], if_a.err_o[0], if_a.rdata_o[31:0]);
    end
    drive_a(0, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
    drive_a(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    idle_all();
    total++;
    if (if_a.rdata_o[31:0] !== 32'h17161514) begin bad++; $display("FAIL be_zero_noop: got %h want 17161514", if_a.rdata_o[31:0]); end
  endtask

  task automatic test_collision();
    drive_a(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h11111111);
    drive_a(1, 1'b1, 1'b1, 4'hF, 32'h20, 32'h22222222);
    step();
    drive_a(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    drive_a(1, 1'b1, 1'b1, 4'hF, 32'h20, 32'h33333333);
    step();
    total++;
    if (if_a.rdata_o[31:0] !== 32'h22222222) begin bad++; $display("FAIL coll_rbw: got %h want 22222222", if_a.rdata_o[31:0]); end
    drive_a(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    drive_a(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    total++;
    if (if_a.rdata_o[31:0] !== 32'h33333333) begin bad++; $display("FAIL coll_after: got %h want 33333333", if_a.rdata_o[31:0]); end
    drive_a(0, 1'b1, 1'b1, 4'b0011, 32'h24, 32'h44444444);
    drive_a(1, 1'b1, 1'b1, 4'b0110, 32'h24, 32'h55555555);
    step();
    drive_a(0, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
    drive_a(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    idle_all();
    total++;
    if (if_a.rdata_o[31:0] !== 32'h27555544) begin bad++; $display("FAIL coll_bytes: got %h want 27555544", if_a.rdata_o[31:0]); end
  endtask

  task automatic test_errors();
    drive_a(0, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    drive_a(1, 1'b1, 1'b1, 4'hF, 32'h1000, 32'hDEADBEEF);
    step();
    total++;
    if (if_a.rvalid_o !== 2'b11 || if_a.err_o !== 2'b11 || if_a.rdata_o !== 64'h0) begin
      bad++; $display("FAIL err_oor: got rvalid %b err %b rdata %h want 11/11/0", if_a.rvalid_o, if_a.err_o, if_a.rdata_o);
    end
    drive_a(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    drive_a(1, 1'b1, 1'b0, 4'hF, 32'h80000004, 32'h0);
    step();
    idle_all();
    total++;
    if (if_a.rdata_o[31:0] !== 32'h03020100 || if_a.err_o[0] !== 1'b0) begin
      bad++; $display("FAIL err_no_alias: got %h err %b want 03020100/0", if_a.rdata_o[31:0], if_a.err_o[0]);
    end
    total++;
    if (if_a.err_o[1] !== 1'b1 || if_a.rdata_o[63:32] !== 32'h0) begin
      bad++; $display("FAIL err_high_bit: got err %b rdata %h want 1/0", if_a.err_o[1], if_a.rdata_o[63:32]);
    end
  endtask

  task automatic test_readonly();
    if_d.req_i = 1'b1; if_d.we_i = 1'b1; if_d.be_i = 4'hF; if_d.addr_i = 32'h0; if_d.wdata_i = 32'hFFFFFFFF;
    step();
    total++;
    if (if_d.rvalid_o !== 1'b1 || if_d.err_o !== 1'b1 || if_d.rdata_o !== 32'h0) begin
      bad++; $display("FAIL ro_wr_err: got rvalid %b err %b rdata %h want 1/1/0", if_d.rvalid_o, if_d.err_o, if_d.rdata_o);
    end
    if_d.we_i = 1'b0;
    step();
    idle_all();
    total++;
    if (if_d.rdata_o !== 32'h03020100 || if_d.err_o !== 1'b0) begin
      bad++; $display("FAIL ro_unchanged: got %h err %b want 03020100/0", if_d.rdata_o, if_d.err_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'h03020100;
    exp_data[1] = 32'h07060504;
    exp_data[2] = 32'h0B0A0908;
    for (int k = 0; k < 7; k++) begin
      if (k < 3) begin
        if_b.req_i = 1'b1; if_b.we_i = 1'b0; if_b.be_i = 4'hF; if_b.addr_i = 32'(4*k);
      end else begin
        if_b.req_i = 1'b0;
      end
      #1;
      total++;
      if (if_b.rvalid_o !== (k >= 3 && k <= 5)) begin
        bad++; $display("FAIL b2b_rvalid cycle %0d: got %b want %b", k, if_b.rvalid_o, (k >= 3 && k <= 5));
      end
      if (k >= 3 && k <= 5) begin
        total++;
        if (if_b.rdata_o !== exp_data[k-3]) begin bad++; $display("FAIL b2b_rdata cycle %0d: got %h want %h", k, if_b.rdata_o, exp_data[k-3]); end
      end
      step();
    end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 11; k++) begin
      rst_c = (k == 2);
      if (k == 0 || k == 2 || k == 5) begin
        if_c.req_i = 1'b1; if_c.we_i = 1'b0; if_c.be_i = 4'hF;
        if_c.addr_i = (k == 0) ? 32'h8 : (k == 2) ? 32'h10 : 32'hC;
      end else begin
        if_c.req_i = 1'b0;
      end
      #1;
      if (k == 0 || k == 2 || k == 5) begin
        total++;
        if (if_c.gnt_o !== (k != 2)) begin bad++; $display("FAIL rstmid_gnt cycle %0d: got %b want %b", k, if_c.gnt_o, (k != 2)); end
      end
      total++;
      if (if_c.rvalid_o !== (k == 9)) begin bad++; $display("FAIL rstmid_rvalid cycle %0d: got %b want %b", k, if_c.rvalid_o, (k == 9)); end
      total++;
      if (if_c.rdata_o !== ((k == 9) ? 32'h0F0E0D0C : 32'h0) || if_c.err_o !== 1'b0) begin
        bad++; $display("FAIL rstmid_data cycle %0d: got %h err %b want %h/0", k, if_c.rdata_o, if_c.err_o, (k == 9) ? 32'h0F0E0D0C : 32'h0);
      end
      step();
    end
    rst_c = 1'b0;
  endtask

  initial begin
    idle_all();
    for (int w = 0; w < 1024; w++) begin
      dut_a.mem_q[w] = pre_word(w);
      dut_b.mem_q[w] = pre_word(w);
      dut_c.mem_q[w] = pre_word(w);
      dut_d.mem_q[w] = pre_word(w);
    end
    test_reset();
    test_preload();
    test_byte_enable();
    test_collision();
    test_errors();
    test_readonly();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
